// File: rtl/divider_seq_if.sv
// divider_seq_if: request/result bundle for the sequential divider
interface divider_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             busy;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  quotient, remainder, ready, busy, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output quotient, remainder, ready, busy, div_by_zero, overflow
    );
endinterface

// File: rtl/divider_seq.sv
// divider_seq: multi-cycle restoring divider with signed mode and error flags
module divider_seq #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input logic          clk,
    input logic          rst,
    divider_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int               CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_LD  = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_q, acc_r, mag_d;
    logic             neg_q, neg_r, ovf_pend;
    logic [WIDTH-1:0] quotient, remainder;
    logic             dbz, ovf;
    logic             accept, smode, dvd_neg, dvs_neg, dvs_zero, min_by_neg1;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   r_sh, trial;
    logic             q_bit;

    // Requests are only taken when no division is in flight
    assign accept      = bus.start && (state == IDLE || state == DONE);
    assign smode       = SIGNED_EN ? bus.signed_mode : 1'b0;
    assign dvd_neg     = smode & bus.dividend[WIDTH-1];
    assign dvs_neg     = smode & bus.divisor[WIDTH-1];
    assign dvd_mag     = dvd_neg ? -bus.dividend : bus.dividend;
    assign dvs_mag     = dvs_neg ? -bus.divisor : bus.divisor;
    assign dvs_zero    = bus.divisor == '0;
    assign min_by_neg1 = smode && bus.dividend == MIN_VAL && bus.divisor == '1;

    // One restoring step: shift in the next dividend bit, keep the trial
    // difference only when it did not borrow
    assign r_sh  = {acc_r, acc_q[WIDTH-1]};
    assign trial = r_sh - {1'b0, mag_d};
    assign q_bit = ~trial[WIDTH];

    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = dbz;
    assign bus.overflow    = ovf;
    assign bus.ready       = state == DONE;
    assign bus.busy        = state == CALC || state == FIX;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state: zero divisor short-circuits straight to DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = accept ? (dvs_zero ? DONE : CALC) : state;
            CALC:       state_nx = cnt == CNT_ONE ? FIX : CALC;
            FIX:        state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // Datapath: latch magnitudes on accept, iterate in CALC, sign-fix in FIX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            acc_q     <= '0;
            acc_r     <= '0;
            mag_d     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ovf_pend  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept && dvs_zero) begin
            quotient  <= '1;
            remainder <= bus.dividend;
            dbz       <= 1'b1;
            ovf       <= 1'b0;
        end else if (accept) begin
            cnt      <= CNT_LD;
            acc_q    <= dvd_mag;
            acc_r    <= '0;
            mag_d    <= dvs_mag;
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            ovf_pend <= min_by_neg1;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
        end else if (state == CALC) begin
            cnt   <= cnt - 1'b1;
            acc_r <= q_bit ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
            acc_q <= {acc_q[WIDTH-2:0], q_bit};
        end else if (state == FIX) begin
            quotient  <= neg_q ? -acc_q : acc_q;
            remainder <= neg_r ? -acc_r : acc_r;
            ovf       <= ovf_pend;
        end
    end
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed table, corner sequences and random sweep for divider_seq
module tb_divider_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_bcnt;
    bit   sel16 = 1'b0;

    always #5 clk = ~clk;

    divider_seq_if #(.WIDTH(8))  b8();
    divider_seq_if #(.WIDTH(16)) b16();

    divider_seq #(.WIDTH(8),  .SIGNED_EN(1'b1)) dut8  (.clk(clk), .rst(rst), .bus(b8));
    divider_seq #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    logic [15:0] q_s, r_s;
    logic        rdy_s, busy_s, dbz_s, ovf_s;

    assign q_s    = sel16 ? b16.quotient    : {8'h00, b8.quotient};
    assign r_s    = sel16 ? b16.remainder   : {8'h00, b8.remainder};
    assign rdy_s  = sel16 ? b16.ready       : b8.ready;
    assign busy_s = sel16 ? b16.busy        : b8.busy;
    assign dbz_s  = sel16 ? b16.div_by_zero : b8.div_by_zero;
    assign ovf_s  = sel16 ? b16.overflow    : b8.overflow;

    typedef struct {
        bit         sm;
        logic [7:0] a, b, q, r;
        logic       dbz, ovf;
    } vec_t;

    vec_t vt[15];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w16, input bit sm, input logic [15:0] a, input logic [15:0] b);
        sel16 = w16;
        if (w16) begin
            b16.start = 1'b1; b16.signed_mode = sm; b16.dividend = a; b16.divisor = b;
        end else begin
            b8.start = 1'b1; b8.signed_mode = sm; b8.dividend = a[7:0]; b8.divisor = b[7:0];
        end
    endtask

    task automatic clear_start();
        b8.start  = 1'b0;
        b16.start = 1'b0;
    endtask

    task automatic wait_ready(inout int lat);
        while (!rdy_s && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy_s) last_bcnt++;
        end
    endtask

    task automatic run_op(input bit w16, input bit sm, input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        drive(w16, sm, a, b);
        @(negedge clk);
        clear_start();
        lat = 1;
        last_bcnt = busy_s ? 1 : 0;
        wait_ready(lat);
    endtask

    task automatic check_op(input string name, input bit w16, input bit sm, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] eq, input logic [15:0] er, input logic edbz, input logic eovf, input int elat);
        int lat;
        run_op(w16, sm, a, b, lat);
        check({name, "_lat"}, 16'(lat), 16'(elat));
        check({name, "_q"}, q_s, eq);
        check({name, "_r"}, r_s, er);
        check({name, "_dbz"}, 16'(dbz_s), 16'(edbz));
        check({name, "_ovf"}, 16'(ovf_s), 16'(eovf));
    endtask

    function automatic void ref_div(input bit w16, input bit sm, input logic [15:0] a_in, input logic [15:0] b_in,
                                    output logic [15:0] q, output logic [15:0] r, output logic dbz, output logic ovf);
        int          ai, bi;
        logic [15:0] m, a, b;
        m   = w16 ? 16'hFFFF : 16'h00FF;
        a   = a_in & m;
        b   = b_in & m;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 16'h0) begin
            q = m; r = a; dbz = 1'b1;
        end else if (sm) begin
            ai  = w16 ? int'($signed(a)) : int'($signed(a[7:0]));
            bi  = w16 ? int'($signed(b)) : int'($signed(b[7:0]));
            q   = 16'(ai / bi) & m;
            r   = 16'(ai % bi) & m;
            ovf = (bi == -1) && (ai == (w16 ? -32768 : -128));
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    initial begin
        int          lat;
        logic [15:0] eq, er, ra, rb;
        logic        edbz, eovf;
        bit          sm, w16;

        vt[0]  = '{1'b0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0};
        vt[1]  = '{1'b1, 8'h9C,  8'h07,  8'hF2,  8'hFE,  1'b0, 1'b0};
        vt[2]  = '{1'b1, 8'd100, 8'hF9,  8'hF2,  8'h02,  1'b0, 1'b0};
        vt[3]  = '{1'b0, 8'd25,  8'd0,   8'hFF,  8'd25,  1'b1, 1'b0};
        vt[4]  = '{1'b0, 8'd55,  8'd5,   8'd11,  8'd0,   1'b0, 1'b0};
        vt[5]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1};
        vt[6]  = '{1'b0, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0, 1'b0};
        vt[7]  = '{1'b1, 8'h9C,  8'hF9,  8'h0E,  8'hFE,  1'b0, 1'b0};
        vt[8]  = '{1'b0, 8'hFF,  8'h01,  8'hFF,  8'h00,  1'b0, 1'b0};
        vt[9]  = '{1'b0, 8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 1'b0};
        vt[10] = '{1'b1, 8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 1'b0};
        vt[11] = '{1'b1, 8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0, 1'b0};
        vt[12] = '{1'b1, 8'h80,  8'h80,  8'h01,  8'h00,  1'b0, 1'b0};
        vt[13] = '{1'b1, 8'h81,  8'h00,  8'hFF,  8'h81,  1'b1, 1'b0};
        vt[14] = '{1'b0, 8'h00,  8'd3,   8'h00,  8'h00,  1'b0, 1'b0};

        clear_start();
        b8.signed_mode = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
        b16.signed_mode = 1'b0; b16.dividend = '0; b16.divisor = '0;

        repeat (2) @(negedge clk);
        check("rst_q", q_s, 16'h0);
        check("rst_r", r_s, 16'h0);
        check("rst_ready", 16'(rdy_s), 16'h0);
        check("rst_busy", 16'(busy_s), 16'h0);
        check("rst_flags", {14'h0, dbz_s, ovf_s}, 16'h0);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            check_op($sformatf("vec%0d", i), 1'b0, vt[i].sm, {8'h0, vt[i].a}, {8'h0, vt[i].b},
                     {8'h0, vt[i].q}, {8'h0, vt[i].r}, vt[i].dbz, vt[i].ovf, vt[i].b == 8'h0 ? 1 : 10);
            if (i == 0) check("vec0_busy_cycles", 16'(last_bcnt), 16'd9);
        end

        check_op("dz", 1'b0, 1'b0, 16'd25, 16'd0, 16'h00FF, 16'd25, 1'b1, 1'b0, 1);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'd55, 16'd5);
        @(negedge clk);
        clear_start();
        lat = 1;
        check("restart_ready_drop", 16'(rdy_s), 16'h0);
        check("restart_dbz_drop", 16'(dbz_s), 16'h0);
        check("restart_q_held", q_s, 16'h00FF);
        check("restart_r_held", r_s, 16'd25);
        check("restart_busy", 16'(busy_s), 16'h1);
        wait_ready(lat);
        check("restart_lat", 16'(lat), 16'd10);
        check("restart_q", q_s, 16'd11);
        check("restart_r", r_s, 16'd0);

        @(negedge clk);
        drive(1'b0, 1'b0, 16'd100, 16'd7);
        @(negedge clk);
        clear_start();
        lat = 1;
        repeat (3) begin @(negedge clk); lat++; end
        drive(1'b0, 1'b1, 16'h00C8, 16'h0003);
        @(negedge clk);
        lat++;
        clear_start();
        b8.dividend = 8'd1; b8.divisor = 8'd1;
        wait_ready(lat);
        check("ignore_lat", 16'(lat), 16'd10);
        check("ignore_q", q_s, 16'd14);
        check("ignore_r", r_s, 16'd2);

        @(negedge clk);
        drive(1'b0, 1'b0, 16'd9, 16'd2);
        @(negedge clk);
        clear_start();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_q", q_s, 16'h0);
        check("arst_r", r_s, 16'h0);
        check("arst_ready", 16'(rdy_s), 16'h0);
        check("arst_busy", 16'(busy_s), 16'h0);
        check("arst_flags", {14'h0, dbz_s, ovf_s}, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        check_op("post_rst", 1'b0, 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 10);

        check_op("w16_u", 1'b1, 1'b0, 16'd60000, 16'd255, 16'd235, 16'd75, 1'b0, 1'b0, 18);
        check_op("w16_ovf", 1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 18);
        check_op("w16_dz", 1'b1, 1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1);

        for (int i = 0; i < 60; i++) begin
            w16 = i >= 30;
            sm  = 1'($urandom_range(0, 1));
            ra  = 16'($urandom);
            rb  = $urandom_range(0, 7) == 0 ? 16'h0 : 16'($urandom);
            if (!w16) begin ra[15:8] = 8'h0; rb[15:8] = 8'h0; end
            ref_div(w16, sm, ra, rb, eq, er, edbz, eovf);
            check_op($sformatf("rnd%0d", i), w16, sm, ra, rb, eq, er, edbz, eovf, edbz ? 1 : (w16 ? 18 : 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
